// File: rtl/id_stage.sv
// rtl/id_stage.sv - MIPS decode stage: register file, decoders, early branch, hazards, ID/EX register (optional BRANCH_FWD_EN)
module id_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cmdD,
    input  logic [31:0] PCPlusFourD,
    input  logic        RegWriteW,
    input  logic [4:0]  WriteRegW,
    input  logic [31:0] ResultW,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic [4:0]  WriteRegM,
    input  logic [31:0] ALUOutM,
    output logic        stallF,
    output logic        stallD,
    output logic        PCSrcD,
    output logic [31:0] PCBranchD,
    output logic        RegWriteE,
    output logic        MemtoRegE,
    output logic        MemWriteE,
    output logic        ALUSrcE,
    output logic [2:0]  ALUControlE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] SignImmE,
    output logic [4:0]  RsE,
    output logic [4:0]  RtE,
    output logic [4:0]  WriteRegE
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] sign_imm;

    assign opcode   = cmdD[31:26];
    assign rs       = cmdD[25:21];
    assign rt       = cmdD[20:16];
    assign rd       = cmdD[15:11];
    assign funct    = cmdD[5:0];
    assign sign_imm = {{16{cmdD[15]}}, cmdD[15:0]};

    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic        alu_src;
    logic [2:0]  alu_ctl;
    logic [4:0]  dst;
    logic        is_beq;
    logic        is_bne;
    logic        is_j;

    // Main + ALU decoder; anything unrecognised decodes to a bubble
    always_comb begin
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        alu_ctl    = 3'b000;
        dst        = 5'd0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_j       = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    6'h20: begin reg_write = 1'b1; alu_ctl = 3'b010; dst = rd; end
                    6'h22: begin reg_write = 1'b1; alu_ctl = 3'b110; dst = rd; end
                    6'h24: begin reg_write = 1'b1; alu_ctl = 3'b000; dst = rd; end
                    6'h25: begin reg_write = 1'b1; alu_ctl = 3'b001; dst = rd; end
                    6'h2a: begin reg_write = 1'b1; alu_ctl = 3'b111; dst = rd; end
                    default: ;
                endcase
            end
            OP_LW: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                alu_src    = 1'b1;
                alu_ctl    = 3'b010;
                dst        = rt;
            end
            OP_SW: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                alu_ctl   = 3'b010;
            end
            OP_ADDI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_ctl   = 3'b010;
                dst       = rt;
            end
            OP_BEQ:  is_beq = 1'b1;
            OP_BNE:  is_bne = 1'b1;
            OP_J:    is_j   = 1'b1;
            default: ;
        endcase
    end

    logic [31:0] regs_q [32];

    // Register file write port; $0 is never written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (RegWriteW && WriteRegW != 5'd0) begin
            regs_q[WriteRegW] <= ResultW;
        end
    end

    logic [31:0] rd1;
    logic [31:0] rd2;

    // Read ports with same-cycle writeback bypass
    always_comb begin
        rd1 = regs_q[rs];
        rd2 = regs_q[rt];
        if (rs == 5'd0) begin
            rd1 = 32'd0;
        end else if (RegWriteW && WriteRegW == rs) begin
            rd1 = ResultW;
        end
        if (rt == 5'd0) begin
            rd2 = 32'd0;
        end else if (RegWriteW && WriteRegW == rt) begin
            rd2 = ResultW;
        end
    end

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        m_hit_rs;
    logic        m_hit_rt;
    logic        e_hit;
    logic        m_branch_hazard;

    assign m_hit_rs = RegWriteM && WriteRegM != 5'd0 && WriteRegM == rs;
    assign m_hit_rt = RegWriteM && WriteRegM != 5'd0 && WriteRegM == rt;
    assign e_hit    = RegWriteE && WriteRegE != 5'd0 && (WriteRegE == rs || WriteRegE == rt);

`ifdef BRANCH_FWD_EN
    // Comparator takes the M-stage ALU result; only a load still in M must wait
    assign op_a = m_hit_rs ? ALUOutM : rd1;
    assign op_b = m_hit_rt ? ALUOutM : rd2;
    assign m_branch_hazard = MemtoRegM && WriteRegM != 5'd0 && (WriteRegM == rs || WriteRegM == rt);
`else
    // Without forwarding any M-stage producer holds the branch until writeback
    logic unused_fwd;
    assign unused_fwd = ^{ALUOutM, MemtoRegM};
    assign op_a = rd1;
    assign op_b = rd2;
    assign m_branch_hazard = m_hit_rs || m_hit_rt;
`endif

    logic eq;
    logic lwstall;
    logic brstall;
    logic stall;

    assign eq      = (op_a == op_b);
    assign lwstall = MemtoRegE && (RtE == rs || RtE == rt);
    assign brstall = (is_beq || is_bne) && (e_hit || m_branch_hazard);
    assign stall   = lwstall || brstall;
    assign stallF  = stall;
    assign stallD  = stall;

    assign PCSrcD    = !stall && (is_j || (is_beq && eq) || (is_bne && !eq));
    assign PCBranchD = is_j ? {PCPlusFourD[31:28], cmdD[25:0], 2'b00}
                            : PCPlusFourD + {sign_imm[29:0], 2'b00};

    logic        reg_write_q, mem_to_reg_q, mem_write_q, alu_src_q;
    logic [2:0]  alu_ctl_q;
    logic [31:0] rd1_q, rd2_q, sign_imm_q;
    logic [4:0]  rs_q, rt_q, dst_q;

    // ID/EX pipeline register; a stall inserts a bubble into execute
    always_ff @(posedge clk or posedge reset) begin
        if (reset || stall) begin
            if (reset) begin
                reg_write_q  <= 1'b0;
            end else begin
                reg_write_q  <= 1'b0;
            end
            mem_to_reg_q <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_ctl_q    <= 3'b000;
            rd1_q        <= 32'd0;
            rd2_q        <= 32'd0;
            sign_imm_q   <= 32'd0;
            rs_q         <= 5'd0;
            rt_q         <= 5'd0;
            dst_q        <= 5'd0;
        end else begin
            reg_write_q  <= reg_write;
            mem_to_reg_q <= mem_to_reg;
            mem_write_q  <= mem_write;
            alu_src_q    <= alu_src;
            alu_ctl_q    <= alu_ctl;
            rd1_q        <= rd1;
            rd2_q        <= rd2;
            sign_imm_q   <= sign_imm;
            rs_q         <= rs;
            rt_q         <= rt;
            dst_q        <= dst;
        end
    end

    assign RegWriteE   = reg_write_q;
    assign MemtoRegE   = mem_to_reg_q;
    assign MemWriteE   = mem_write_q;
    assign ALUSrcE     = alu_src_q;
    assign ALUControlE = alu_ctl_q;
    assign RD1E        = rd1_q;
    assign RD2E        = rd2_q;
    assign SignImmE    = sign_imm_q;
    assign RsE         = rs_q;
    assign RtE         = rt_q;
    assign WriteRegE   = dst_q;

endmodule
